// File: rtl/lpc_io_target_if.sv
// LPC bus signals between the host (master) and the I/O target (slave).
interface lpc_io_target_if;
  logic       LFrame_n;
  logic [3:0] LadIn;
  logic [3:0] LadOut;
  logic       LadOe;

  modport master (
    output LFrame_n,
    output LadIn,
    input  LadOut,
    input  LadOe
  );

  modport slave (
    input  LFrame_n,
    input  LadIn,
    output LadOut,
    output LadOe
  );
endinterface

// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target front end for the CPLD register file (32-byte window at BASE_ADDR).
// Define LPC_IO_WRITE_EN to decode I/O write cycles; otherwise only reads are served.
module lpc_io_target #(
  parameter logic [15:0] BASE_ADDR = 16'h0700
) (
  input  logic           LpcClock,
  input  logic           PciReset,
  lpc_io_target_if.slave lpc,
  output logic [7:0]     AddrReg,
  input  logic [7:0]     DataRd,
  output logic [7:0]     WrData,
  output logic           WrStrobe
);

  typedef enum logic [3:0] {
    IDLE,
    START,
    CYCTYPE,
    ADDR,
`ifdef LPC_IO_WRITE_EN
    WDATA0,
    WDATA1,
`endif
    HTAR0,
    HTAR1,
    SYNC,
    RDATA0,
    RDATA1,
    PTAR0,
    PTAR1
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic [11:0] r_addr;
  logic [7:0]  r_hold;
  logic [3:0]  r_LadOut;
  logic        r_LadOe;
  logic [7:0]  r_AddrReg;
  logic [15:0] w_addr;
  logic        w_hit;
  logic        w_start;
  logic        w_load_addr;
  logic        w_is_write;

  assign w_addr  = {r_addr, lpc.LadIn};
  assign w_hit   = (w_addr[15:5] == BASE_ADDR[15:5]);
  assign w_start = !lpc.LFrame_n && (lpc.LadIn == 4'h0);

`ifdef LPC_IO_WRITE_EN
  logic       r_write;
  logic [3:0] r_wlo;
  logic [7:0] r_wdata;
  logic [7:0] r_WrData;
  logic       r_WrStrobe;

  assign w_is_write = r_write;
  assign WrData     = r_WrData;
  assign WrStrobe   = r_WrStrobe;
`else
  assign w_is_write = 1'b0;
  assign WrData     = '0;
  assign WrStrobe   = 1'b0;
`endif

  assign lpc.LadOut = r_LadOut;
  assign lpc.LadOe  = r_LadOe;
  assign AddrReg    = r_AddrReg;

  // The cycle type is decoded while START sees LFrame_n high; the CYCTYPE state
  // then takes the first address nibble so the address still ends at T5.
  always_comb begin
    w_next      = r_state;
    w_load_addr = 1'b0;
    if ((r_state != IDLE) && (r_state != START) && !lpc.LFrame_n) begin
      w_next = w_start ? START : IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_start) w_next = START;
        START: begin
          if (lpc.LFrame_n) begin
            if (lpc.LadIn[3:1] == 3'b000)
              w_next = CYCTYPE;
`ifdef LPC_IO_WRITE_EN
            else if (lpc.LadIn[3:1] == 3'b001)
              w_next = CYCTYPE;
`endif
            else
              w_next = IDLE;
          end else if (!w_start) begin
            w_next = IDLE;
          end
        end
        CYCTYPE: w_next = ADDR;
        ADDR: begin
          if (r_cnt == 2'd3) begin
            if (!w_hit) begin
              w_next = IDLE;
            end else begin
              w_load_addr = 1'b1;
`ifdef LPC_IO_WRITE_EN
              w_next = r_write ? WDATA0 : HTAR0;
`else
              w_next = HTAR0;
`endif
            end
          end
        end
`ifdef LPC_IO_WRITE_EN
        WDATA0:  w_next = WDATA1;
        WDATA1:  w_next = HTAR0;
`endif
        HTAR0:   w_next = HTAR1;
        HTAR1:   w_next = SYNC;
        SYNC:    w_next = w_is_write ? PTAR0 : RDATA0;
        RDATA0:  w_next = RDATA1;
        RDATA1:  w_next = PTAR0;
        PTAR0:   w_next = PTAR1;
        PTAR1:   w_next = w_start ? START : IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_hold <= '0;
    end else begin
      if (r_state == CYCTYPE) begin
        r_cnt  <= 2'd1;
        r_addr <= {r_addr[7:0], lpc.LadIn};
      end else if (r_state == ADDR) begin
        r_cnt  <= r_cnt + 2'd1;
        r_addr <= {r_addr[7:0], lpc.LadIn};
      end
      if (r_state == SYNC) r_hold <= DataRd;
    end
  end

  // Outputs are registered from the next state so they line up with that state's clock;
  // the low data nibble is taken straight from DataRd on the same edge that fills r_hold.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_LadOut  <= '1;
      r_LadOe   <= 1'b0;
      r_AddrReg <= '0;
    end else begin
      r_LadOe <= (w_next == SYNC) || (w_next == RDATA0) ||
                 (w_next == RDATA1) || (w_next == PTAR0);
      case (w_next)
        SYNC:    r_LadOut <= 4'h0;
        RDATA0:  r_LadOut <= DataRd[3:0];
        RDATA1:  r_LadOut <= r_hold[7:4];
        default: r_LadOut <= 4'hF;
      endcase
      if (w_load_addr) r_AddrReg <= {3'b000, w_addr[4:0]};
    end
  end

`ifdef LPC_IO_WRITE_EN
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_write    <= 1'b0;
      r_wlo      <= '0;
      r_wdata    <= '0;
      r_WrData   <= '0;
      r_WrStrobe <= 1'b0;
    end else begin
      if ((r_state == START) && lpc.LFrame_n) r_write <= (lpc.LadIn[3:1] == 3'b001);
      if (r_state == WDATA0) r_wlo <= lpc.LadIn;
      if (r_state == WDATA1) r_wdata <= {lpc.LadIn, r_wlo};
      r_WrStrobe <= (w_next == SYNC) && r_write;
      if ((w_next == SYNC) && r_write) r_WrData <= r_wdata;
    end
  end
`endif

endmodule

// File: tb/tb_lpc_io_target.sv
// Randomized scoreboard bench for lpc_io_target: stimulus queues expected LAD drives and
// write strobes with their absolute clock numbers; a negedge monitor pops and compares.
module tb_lpc_io_target;

  localparam logic [15:0] BASE = 16'h0700;
`ifdef LPC_IO_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic       LpcClock = 1'b0;
  logic       PciReset;
  logic [7:0] AddrReg;
  logic [7:0] DataRd;
  logic [7:0] WrData;
  logic       WrStrobe;

  lpc_io_target_if bus();

  lpc_io_target #(.BASE_ADDR(BASE)) dut (
    .LpcClock (LpcClock),
    .PciReset (PciReset),
    .lpc      (bus),
    .AddrReg  (AddrReg),
    .DataRd   (DataRd),
    .WrData   (WrData),
    .WrStrobe (WrStrobe)
  );

  always #15 LpcClock = ~LpcClock;

  int cyc = 0;
  always @(posedge LpcClock) cyc <= cyc + 1;

  // Read-data mux model: registered lookup of the decoded offset.
  logic [7:0] mem [256];
  always @(posedge LpcClock) DataRd <= mem[AddrReg];

  typedef struct { int c; logic [3:0] nib; } lad_t;
  typedef struct { int c; logic [7:0] off; logic [7:0] data; } wr_t;
  lad_t lad_q[$];
  wr_t  wr_q[$];
  lad_t me;
  wr_t  mw;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_addr = 8'h00;
  logic [7:0] exp_wr   = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  always @(negedge LpcClock) begin
    if (PciReset) begin
      if (bus.LadOe === 1'b1) begin
        if (lad_q.size() == 0) begin
          chk("lad_spurious_oe", 32'(bus.LadOe), 32'd0);
        end else begin
          me = lad_q.pop_front();
          chk("lad_cycle", cyc, me.c);
          chk("lad_nibble", 32'(bus.LadOut), 32'(me.nib));
        end
      end else if (lad_q.size() > 0 && lad_q[0].c <= cyc) begin
        me = lad_q.pop_front();
        chk("lad_oe_missing", 32'(bus.LadOe), 32'd1);
      end
      if (WrStrobe === 1'b1) begin
        if (wr_q.size() == 0) begin
          chk("wr_spurious_strobe", 32'(WrStrobe), 32'd0);
        end else begin
          mw = wr_q.pop_front();
          chk("wr_cycle", cyc, mw.c);
          chk("wr_data", 32'(WrData), 32'(mw.data));
          chk("wr_addrreg", 32'(AddrReg), 32'(mw.off));
        end
      end else if (wr_q.size() > 0 && wr_q[0].c <= cyc) begin
        mw = wr_q.pop_front();
        chk("wr_strobe_missing", 32'(WrStrobe), 32'd1);
      end
    end
  end

  task automatic drive(input logic lf, input logic [3:0] lad);
    @(posedge LpcClock);
    #1;
    bus.LFrame_n = lf;
    bus.LadIn    = lad;
  endtask

  // kind: 0 read, 1 write, 2 reserved cycle type. abort_k/rst_k: clock of abort/reset, 0 = none.
  task automatic run_txn(input int kind, input logic [15:0] addr, input logic [7:0] data,
                         input int abort_k, input int rst_k, input int extra_start, input int gap);
    logic       lf [12];
    logic [3:0] nb [12];
    logic [7:0] off;
    logic [7:0] rd;
    logic       hit;
    logic       valid;
    logic       addr_seen;
    int         t0;
    hit   = (addr[15:5] == BASE[15:5]);
    valid = (kind == 0) || (kind == 1 && WR_EN);
    off   = {3'b000, addr[4:0]};
    rd    = mem[off];
    for (int k = 0; k < 12; k++) begin
      lf[k] = 1'b1;
      nb[k] = 4'hF;
    end
    nb[1] = (kind == 0) ? 4'h0 : (kind == 1) ? 4'h2 : 4'($urandom_range(4, 15));
    nb[2] = addr[15:12];
    nb[3] = addr[11:8];
    nb[4] = addr[7:4];
    nb[5] = addr[3:0];
    if (kind == 1) begin
      nb[6] = data[3:0];
      nb[7] = data[7:4];
    end
    if (abort_k > 0) begin
      lf[abort_k] = 1'b0;
      nb[abort_k] = 4'hF;
    end
    addr_seen = hit && valid && (abort_k == 0 || abort_k >= 6);

    for (int i = 0; i < extra_start; i++) drive(1'b0, 4'h0);
    drive(1'b0, 4'h0);
    t0 = cyc;
    if (hit && valid && abort_k == 0) begin
      if (kind == 0) begin
        lad_q.push_back('{t0 + 8,  4'h0});
        lad_q.push_back('{t0 + 9,  rd[3:0]});
        lad_q.push_back('{t0 + 10, rd[7:4]});
        lad_q.push_back('{t0 + 11, 4'hF});
      end else begin
        lad_q.push_back('{t0 + 10, 4'h0});
        lad_q.push_back('{t0 + 11, 4'hF});
        wr_q.push_back('{t0 + 10, off, data});
        exp_wr = data;
      end
    end
    if (addr_seen) exp_addr = off;

    for (int k = 1; k < 12; k++) begin
      drive(lf[k], nb[k]);
      if (k == 6 && addr_seen) begin
        @(negedge LpcClock);
        chk("addrreg_T6", 32'(AddrReg), 32'(off));
      end
      if (k == rst_k) begin
        @(negedge LpcClock);
        #2 PciReset = 1'b0;
        #1;
        chk("rst_ladoe", 32'(bus.LadOe), 32'd0);
        chk("rst_ladout", 32'(bus.LadOut), 32'hF);
        chk("rst_addrreg", 32'(AddrReg), 32'h00);
        lad_q.delete();
        wr_q.delete();
        exp_addr = 8'h00;
        exp_wr   = 8'h00;
        @(posedge LpcClock);
        #3 PciReset = 1'b1;
        break;
      end
    end
    @(negedge LpcClock);
    chk("addrreg_hold", 32'(AddrReg), 32'(exp_addr));
    chk("wrdata_hold", 32'(WrData), 32'(exp_wr));
    for (int i = 0; i < gap; i++) drive(1'b1, 4'hF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [15:0] a;
    int          r;
    bus.LFrame_n = 1'b1;
    bus.LadIn    = 4'hF;
    PciReset     = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[1] = 8'h5A;
    repeat (3) @(posedge LpcClock);
    @(negedge LpcClock);
    chk("reset_ladout", 32'(bus.LadOut), 32'hF);
    chk("reset_ladoe", 32'(bus.LadOe), 32'd0);
    chk("reset_addrreg", 32'(AddrReg), 32'h00);
    chk("reset_wrdata", 32'(WrData), 32'h00);
    chk("reset_wrstrobe", 32'(WrStrobe), 32'd0);
    @(posedge LpcClock);
    #3 PciReset = 1'b1;

    run_txn(0, 16'h0701, 8'h00, 0, 0, 0, 1);
    run_txn(1, 16'h070E, 8'hC3, 0, 0, 0, 0);
    run_txn(0, 16'h0720, 8'h00, 0, 0, 1, 0);
    run_txn(0, 16'h0702, 8'h00, 0, 0, 0, 0);
    run_txn(1, 16'h0705, 8'h99, 7, 0, 0, 1);
    run_txn(0, 16'h0713, 8'h00, 0, 9, 0, 1);
    run_txn(1, 16'h0700, 8'h3C, 0, 0, 1, 0);
    run_txn(2, 16'h0704, 8'h00, 0, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 3) != 0) begin
        a = {BASE[15:5], 5'($urandom)};
      end else begin
        a = 16'($urandom);
        while (a[15:5] == BASE[15:5]) a = 16'($urandom);
      end
      run_txn((r < 4) ? 0 : (r < 8) ? 1 : 2, a, 8'($urandom),
              ($urandom_range(0, 5) == 0) ? $urandom_range(2, 7) : 0,
              0, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    repeat (4) drive(1'b1, 4'hF);
    @(negedge LpcClock);
    chk("lad_queue_drained", lad_q.size(), 32'd0);
    chk("wr_queue_drained", wr_q.size(), 32'd0);
    chk("final_ladoe", 32'(bus.LadOe), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
